// File: rtl/csr_regbank_pkg.sv
// Shared types, register offsets and address decode helper for the CSR slave register bank.
package csr_regbank_pkg;

   localparam int unsigned CMD_OFS      = 0;
   localparam int unsigned IRQ_STAT_OFS = 4;
   localparam int unsigned IRQ_EN_OFS   = 8;
   localparam int unsigned CSR_DW       = 32;

   typedef struct packed {
      logic [CSR_DW-1:0] rdata;
      logic              err;
   } csr_rsp_t;

   typedef struct packed {
      logic       hit;
      logic [5:0] idx;
   } addr_hit_t;

   // Word index of addr inside [base, base + 4*n); alignment is checked by the caller.
   function automatic addr_hit_t addr_hit(input logic [31:0] addr,
                                          input logic [31:0] base,
                                          input logic [31:0] n);
      addr_hit_t   r;
      logic [31:0] ofs;
      ofs   = addr - base;
      r.hit = (addr >= base) && ({2'b00, ofs[31:2]} < n);
      r.idx = ofs[7:2];
      return r;
   endfunction

endpackage

// File: rtl/csr_rsp_slot.sv
// Single-entry response holding register; one cycle from accept to out_vld_o.
// in_rdy_o = !full || out_rdy_i, so the slot drains and refills in the same cycle.
module csr_rsp_slot
   import csr_regbank_pkg::*;
(
   input  logic     clk_i,
   input  logic     rst_i,
   input  logic     in_vld_i,
   output logic     in_rdy_o,
   input  csr_rsp_t in_dat_i,
   output logic     out_vld_o,
   input  logic     out_rdy_i,
   output csr_rsp_t out_dat_o
);

   logic     vld_q, vld_d;
   csr_rsp_t dat_q, dat_d;

   assign in_rdy_o  = !vld_q || out_rdy_i;
   assign out_vld_o = vld_q;
   assign out_dat_o = dat_q;

   always_comb begin
      vld_d = vld_q;
      dat_d = dat_q;
      if (in_vld_i && in_rdy_o) begin
         vld_d = 1'b1;
         dat_d = in_dat_i;
      end else if (out_rdy_i) begin
         vld_d = 1'b0;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         vld_q <= 1'b0;
         dat_q <= '0;
      end else begin
         vld_q <= vld_d;
         dat_q <= dat_d;
      end
   end

endmodule

// File: rtl/csr_slave_regbank.sv
// CSR slave: RW config words, RO status words, command pulse, sticky IRQ stat/enable.
// Response registered one cycle after accept; csr_ready drops while an unconsumed response is held.
module csr_slave_regbank
   import csr_regbank_pkg::*;
#(
   parameter int unsigned                 AW       = 16,
   parameter int unsigned                 DW       = 32,
   parameter int unsigned                 SW       = DW/8,
   parameter int unsigned                 CFG_NUM  = 8,
   parameter int unsigned                 STA_NUM  = 4,
   parameter int unsigned                 IRQ_NUM  = 8,
   parameter int unsigned                 STA_BASE = 'h000,
   parameter int unsigned                 CFG_BASE = 'h100,
   parameter int unsigned                 CMD_BASE = 'h200,
   parameter logic [CFG_NUM-1:0][DW-1:0] CFG_RST  = {CFG_NUM{32'h1}}
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  clear,
   input  logic                  csr_valid,
   output logic                  csr_ready,
   input  logic                  csr_write,
   input  logic [AW-1:0]         csr_addr,
   input  logic [DW-1:0]         csr_wdata,
   input  logic [SW-1:0]         csr_wstrb,
   output logic                  csr_rvalid,
   input  logic                  csr_rready,
   output logic [DW-1:0]         csr_rdata,
   output logic                  csr_err,
   input  logic [STA_NUM*DW-1:0] sta_in,
   output logic [CFG_NUM*DW-1:0] cfg_out,
   output logic                  cmd_valid,
   output logic [DW-1:0]         cmd_data,
   input  logic [IRQ_NUM-1:0]    irq_event,
   output logic                  irq
);

   if (DW != 32) begin : g_dw_chk
      $error("csr_slave_regbank: DW must be 32");
   end
   if (CFG_NUM < 1 || CFG_NUM > 64 || STA_NUM < 1 || STA_NUM > 64 ||
       IRQ_NUM < 1 || IRQ_NUM > 32) begin : g_num_chk
      $error("csr_slave_regbank: CFG_NUM/STA_NUM/IRQ_NUM out of range");
   end

   localparam logic [5:0] CMD_IDX  = 6'(CMD_OFS / 4);
   localparam logic [5:0] STAT_IDX = 6'(IRQ_STAT_OFS / 4);
   localparam logic [5:0] EN_IDX   = 6'(IRQ_EN_OFS / 4);

   logic                        accept;
   logic [31:0]                 addr32;
   addr_hit_t                   sta_h, cfg_h, cmd_h;
   logic                        aligned, mapped, err;
   logic                        is_cmd, is_stat, is_en;
   logic [CFG_NUM-1:0]          cfg_sel;
   logic [STA_NUM-1:0]          sta_sel;
   logic [DW-1:0]               wmask, rd_mux;
   logic                        wr_ok;
   csr_rsp_t                    rsp_d, rsp_q;

   logic [CFG_NUM-1:0][DW-1:0]  cfg_q, cfg_d;
   logic [IRQ_NUM-1:0]          stat_q, stat_d, en_q, en_d, w1c;
   logic                        irq_q;
   logic                        cmd_valid_q;
   logic [DW-1:0]               cmd_data_q;

   assign accept = csr_valid && csr_ready;
   assign addr32 = 32'(csr_addr);

   // Decode and read mux: every region produces a one-hot select, muxed by AND-OR.
   always_comb begin
      sta_h   = addr_hit(addr32, STA_BASE, STA_NUM);
      cfg_h   = addr_hit(addr32, CFG_BASE, CFG_NUM);
      cmd_h   = addr_hit(addr32, CMD_BASE, 32'd3);
      aligned = (csr_addr[1:0] == 2'b00);
      is_cmd  = cmd_h.hit && (cmd_h.idx == CMD_IDX);
      is_stat = cmd_h.hit && (cmd_h.idx == STAT_IDX);
      is_en   = cmd_h.hit && (cmd_h.idx == EN_IDX);
      mapped  = sta_h.hit || cfg_h.hit || cmd_h.hit;
      err     = !aligned || !mapped || (csr_write && sta_h.hit) || (!csr_write && is_cmd);

      cfg_sel = '0;
      for (int i = 0; i < CFG_NUM; i++) begin
         cfg_sel[i] = cfg_h.hit && (cfg_h.idx == 6'(i));
      end
      sta_sel = '0;
      for (int i = 0; i < STA_NUM; i++) begin
         sta_sel[i] = sta_h.hit && (sta_h.idx == 6'(i));
      end

      rd_mux = '0;
      for (int i = 0; i < CFG_NUM; i++) begin
         if (cfg_sel[i]) rd_mux |= cfg_q[i];
      end
      for (int i = 0; i < STA_NUM; i++) begin
         if (sta_sel[i]) rd_mux |= sta_in[i*DW +: DW];
      end
      if (is_stat) rd_mux[IRQ_NUM-1:0] |= stat_q;
      if (is_en)   rd_mux[IRQ_NUM-1:0] |= en_q;

      rsp_d.rdata = (csr_write || err) ? '0 : rd_mux;
      rsp_d.err   = err;
   end

   // Write path; clear overrides both writes and irq events.
   always_comb begin
      wr_ok = accept && csr_write && !err && !clear;
      wmask = '0;
      for (int b = 0; b < SW; b++) begin
         wmask[b*8 +: 8] = {8{csr_wstrb[b]}};
      end

      cfg_d = cfg_q;
      for (int i = 0; i < CFG_NUM; i++) begin
         if (wr_ok && cfg_sel[i]) cfg_d[i] = (cfg_q[i] & ~wmask) | (csr_wdata & wmask);
      end

      w1c    = (wr_ok && is_stat) ? (csr_wdata[IRQ_NUM-1:0] & wmask[IRQ_NUM-1:0]) : '0;
      stat_d = (stat_q & ~w1c) | irq_event;

      en_d = en_q;
      if (wr_ok && is_en) begin
         en_d = (en_q & ~wmask[IRQ_NUM-1:0]) | (csr_wdata[IRQ_NUM-1:0] & wmask[IRQ_NUM-1:0]);
      end

      if (clear) begin
         cfg_d  = CFG_RST;
         stat_d = '0;
         en_d   = '0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cfg_q       <= CFG_RST;
         stat_q      <= '0;
         en_q        <= '0;
         irq_q       <= 1'b0;
         cmd_valid_q <= 1'b0;
         cmd_data_q  <= '0;
      end else begin
         cfg_q       <= cfg_d;
         stat_q      <= stat_d;
         en_q        <= en_d;
         irq_q       <= |(stat_q & en_q);
         cmd_valid_q <= wr_ok && is_cmd;
         if (wr_ok && is_cmd) cmd_data_q <= csr_wdata;
      end
   end

   csr_rsp_slot u_rsp_slot (
      .clk_i     (clk),
      .rst_i     (rst),
      .in_vld_i  (csr_valid),
      .in_rdy_o  (csr_ready),
      .in_dat_i  (rsp_d),
      .out_vld_o (csr_rvalid),
      .out_rdy_i (csr_rready),
      .out_dat_o (rsp_q)
   );

   assign csr_rdata = rsp_q.rdata;
   assign csr_err   = rsp_q.err;
   assign cfg_out   = cfg_q;
   assign cmd_valid = cmd_valid_q;
   assign cmd_data  = cmd_data_q;
   assign irq       = irq_q;

endmodule

// File: tb/tb_csr_slave_regbank.sv
// Directed bench for csr_slave_regbank with hand-computed expectations.
module tb_csr_slave_regbank;

   localparam int AW = 16, DW = 32, SW = 4, CFG_NUM = 8, STA_NUM = 4, IRQ_NUM = 8;
   localparam logic [15:0] STA_B = 16'h000, CFG_B = 16'h100, CMD_B = 16'h200;

   logic                  clk = 1'b0;
   logic                  rst, clear;
   logic                  csr_valid, csr_ready, csr_write;
   logic [AW-1:0]         csr_addr;
   logic [DW-1:0]         csr_wdata;
   logic [SW-1:0]         csr_wstrb;
   logic                  csr_rvalid, csr_rready;
   logic [DW-1:0]         csr_rdata;
   logic                  csr_err;
   logic [STA_NUM*DW-1:0] sta_in;
   logic [CFG_NUM*DW-1:0] cfg_out;
   logic                  cmd_valid;
   logic [DW-1:0]         cmd_data;
   logic [IRQ_NUM-1:0]    irq_event;
   logic                  irq;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   csr_slave_regbank dut (
      .clk(clk), .rst(rst), .clear(clear),
      .csr_valid(csr_valid), .csr_ready(csr_ready), .csr_write(csr_write),
      .csr_addr(csr_addr), .csr_wdata(csr_wdata), .csr_wstrb(csr_wstrb),
      .csr_rvalid(csr_rvalid), .csr_rready(csr_rready), .csr_rdata(csr_rdata),
      .csr_err(csr_err), .sta_in(sta_in), .cfg_out(cfg_out),
      .cmd_valid(cmd_valid), .cmd_data(cmd_data), .irq_event(irq_event), .irq(irq)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic req(input logic wr, input logic [15:0] a, input logic [31:0] d, input logic [3:0] s);
      int n;
      n         = 0;
      csr_valid = 1'b1;
      csr_write = wr;
      csr_addr  = a;
      csr_wdata = d;
      csr_wstrb = s;
      while (!csr_ready && n < 20) begin
         step();
         n++;
      end
      if (n >= 20) chk("req_ready_timeout", {31'b0, csr_ready}, 32'h1);
      step();
      csr_valid = 1'b0;
      csr_write = 1'b0;
   endtask

   task automatic rsp(input string tag, input logic [31:0] rd, input logic e);
      chk({tag, "_rvalid"}, {31'b0, csr_rvalid}, 32'h1);
      chk({tag, "_rdata"}, csr_rdata, rd);
      chk({tag, "_err"}, {31'b0, csr_err}, {31'b0, e});
   endtask

   initial begin
      rst = 1'b1; clear = 1'b0; csr_valid = 1'b0; csr_write = 1'b0;
      csr_addr = '0; csr_wdata = '0; csr_wstrb = '0; csr_rready = 1'b1;
      sta_in = {32'hCAFE_0003, 32'h1234_5678, 32'hCAFE_0001, 32'hCAFE_0000};
      irq_event = '0;
      step(); step();
      chk("rst_rvalid", {31'b0, csr_rvalid}, 32'h0);
      chk("rst_rdata", csr_rdata, 32'h0);
      chk("rst_err", {31'b0, csr_err}, 32'h0);
      chk("rst_cmd_valid", {31'b0, cmd_valid}, 32'h0);
      chk("rst_cmd_data", cmd_data, 32'h0);
      chk("rst_irq", {31'b0, irq}, 32'h0);
      chk("rst_cfg0", cfg_out[31:0], 32'h1);
      chk("rst_cfg7", cfg_out[7*32 +: 32], 32'h1);
      rst = 1'b0;
      step();

      // 1: default config read, exactly one beat
      req(1'b0, CFG_B + 16'h4, 32'h0, 4'h0);
      rsp("t1_read_cfg1", 32'h1, 1'b0);
      step();
      chk("t1_single_beat", {31'b0, csr_rvalid}, 32'h0);

      // 2: strobed config write
      req(1'b1, CFG_B, 32'hAABB_CCDD, 4'b0101);
      rsp("t2_write", 32'h0, 1'b0);
      chk("t2_cfg0_out", cfg_out[31:0], 32'h00BB_00DD);
      req(1'b0, CFG_B, 32'h0, 4'h0);
      rsp("t2_readback", 32'h00BB_00DD, 1'b0);
      req(1'b0, STA_B + 16'h8, 32'h0, 4'h0);
      rsp("t2_sta2", 32'h1234_5678, 1'b0);
      step();

      // 3: response backpressure
      csr_rready = 1'b0;
      req(1'b0, CFG_B + 16'h4, 32'h0, 4'h0);
      csr_valid = 1'b1; csr_write = 1'b0; csr_addr = CFG_B;
      for (int k = 0; k < 3; k++) begin
         chk("t3_ready_low", {31'b0, csr_ready}, 32'h0);
         rsp("t3_hold", 32'h1, 1'b0);
         step();
      end
      csr_rready = 1'b1;
      #1;
      chk("t3_ready_refill", {31'b0, csr_ready}, 32'h1);
      step();
      csr_valid = 1'b0;
      rsp("t3_second", 32'h00BB_00DD, 1'b0);

      // 4: interrupts
      req(1'b1, CMD_B + 16'h8, 32'hFFFF_FF01, 4'hF);
      req(1'b0, CMD_B + 16'h8, 32'h0, 4'h0);
      rsp("t4_en_read", 32'h0000_0001, 1'b0);
      irq_event = 8'h01;
      step();
      irq_event = 8'h00;
      chk("t4_irq_lag", {31'b0, irq}, 32'h0);
      step();
      chk("t4_irq_set", {31'b0, irq}, 32'h1);
      irq_event = 8'h01;
      req(1'b1, CMD_B + 16'h4, 32'h1, 4'hF);
      irq_event = 8'h00;
      req(1'b0, CMD_B + 16'h4, 32'h0, 4'h0);
      rsp("t4_set_wins", 32'h1, 1'b0);
      chk("t4_irq_held", {31'b0, irq}, 32'h1);
      req(1'b1, CMD_B + 16'h4, 32'hFFFF_FFFF, 4'hF);
      step();
      chk("t4_irq_clr", {31'b0, irq}, 32'h0);
      irq_event = 8'hF0;
      step();
      irq_event = 8'h00;
      req(1'b0, CMD_B + 16'h4, 32'h0, 4'h0);
      rsp("t4_stat_masked_src", 32'h0000_00F0, 1'b0);
      step();
      chk("t4_irq_disabled_src", {31'b0, irq}, 32'h0);

      // 5: error responses
      req(1'b1, STA_B, 32'hDEAD_BEEF, 4'hF);
      rsp("t5_sta_write", 32'h0, 1'b1);
      req(1'b0, 16'h03FC, 32'h0, 4'h0);
      rsp("t5_unmapped", 32'h0, 1'b1);
      req(1'b0, CFG_B + 16'h2, 32'h0, 4'h0);
      rsp("t5_misaligned", 32'h0, 1'b1);
      req(1'b1, CFG_B + 16'h2, 32'hFFFF_FFFF, 4'hF);
      rsp("t5_misaligned_wr", 32'h0, 1'b1);
      req(1'b0, CMD_B, 32'h0, 4'h0);
      rsp("t5_cmd_read", 32'h0, 1'b1);
      chk("t5_cfg0_kept", cfg_out[31:0], 32'h00BB_00DD);
      chk("t5_cmd_quiet", {31'b0, cmd_valid}, 32'h0);

      // soft clear wins over a same-cycle write, response still returned
      clear = 1'b1;
      req(1'b1, CFG_B + 16'h4, 32'h0000_0055, 4'hF);
      clear = 1'b0;
      rsp("clr_write_rsp", 32'h0, 1'b0);
      chk("clr_cfg1", cfg_out[32 +: 32], 32'h1);
      chk("clr_cfg0", cfg_out[31:0], 32'h1);
      req(1'b0, CMD_B + 16'h8, 32'h0, 4'h0);
      rsp("clr_en", 32'h0, 1'b0);
      req(1'b0, CMD_B + 16'h4, 32'h0, 4'h0);
      rsp("clr_stat", 32'h0, 1'b0);

      // 6: back-to-back command writes, then reset mid-burst
      step();
      csr_valid = 1'b1; csr_write = 1'b1; csr_addr = CMD_B; csr_wstrb = 4'h0;
      csr_wdata = 32'h5;
      step();
      chk("t6_cmd1_valid", {31'b0, cmd_valid}, 32'h1);
      chk("t6_cmd1_data", cmd_data, 32'h5);
      csr_wdata = 32'h7;
      step();
      chk("t6_cmd2_valid", {31'b0, cmd_valid}, 32'h1);
      chk("t6_cmd2_data", cmd_data, 32'h7);
      csr_wdata = 32'h9;
      rst = 1'b1;
      step();
      chk("t6_rst_cmd_valid", {31'b0, cmd_valid}, 32'h0);
      chk("t6_rst_cmd_data", cmd_data, 32'h0);
      chk("t6_rst_rvalid", {31'b0, csr_rvalid}, 32'h0);
      chk("t6_rst_rdata", csr_rdata, 32'h0);
      chk("t6_rst_err", {31'b0, csr_err}, 32'h0);
      chk("t6_rst_irq", {31'b0, irq}, 32'h0);
      chk("t6_rst_cfg0", cfg_out[31:0], 32'h1);
      rst = 1'b0;
      csr_valid = 1'b0; csr_write = 1'b0;
      step();
      chk("t6_post_rst_cmd", {31'b0, cmd_valid}, 32'h0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/csr_slave_regbank.md
Name: csr_slave_regbank

Overview:
- Parametrised CSR slave register bank, successor to the fixed per-block CSR slaves.
- Provides:
  - CFG_NUM read/write config words with byte strobes and per-word reset defaults.
  - STA_NUM read-only status words.
  - A command pulse register.
  - A sticky interrupt status/enable pair with a level IRQ output.
- Sits between the CSR fabric and a compute unit.
- Adds two things the fixed slaves lack: a registered response channel with backpressure, and error reporting.

Parameters:
- AW, 16, address width.
- DW, 32, data width. Fixed at 32; elaboration error otherwise.
- SW, DW/8, strobe width.
- CFG_NUM, 8, number of config words (1..64).
- STA_NUM, 4, number of status words (1..64).
- IRQ_NUM, 8, number of interrupt sources (1..32).
- STA_BASE, 'h000, byte address of status word 0.
- CFG_BASE, 'h100, byte address of config word 0.
- CMD_BASE, 'h200, byte address of the command / IRQ block.
- CFG_RST, all 32'h1, packed [CFG_NUM-1:0][DW-1:0] reset/clear defaults.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- clear  in  1  synchronous soft clear of register state
- csr_valid  in  1  request valid
- csr_ready  out  1  request accepted when valid&ready
- csr_write  in  1  1=write, 0=read
- csr_addr  in  AW  byte address
- csr_wdata  in  DW  write data
- csr_wstrb  in  SW  byte enables
- csr_rvalid  out  1  response valid
- csr_rready  in  1  response consumed when rvalid&rready
- csr_rdata  out  DW  read data (0 for writes and errors)
- csr_err  out  1  response error flag
- sta_in  in  STA_NUM*DW  status words, sampled at accept
- cfg_out  out  CFG_NUM*DW  config register contents
- cmd_valid  out  1  one-cycle pulse on an accepted CMD write
- cmd_data  out  DW  wdata registered with cmd_valid
- irq_event  in  IRQ_NUM  per-source set pulses
- irq  out  1  |(irq_stat & irq_en)

Behaviour:
- One clock, `clk`. Reset `rst` is synchronous and active-high.
- Reset values:
  - cfg = CFG_RST.
  - irq_stat = 0, irq_en = 0, irq = 0.
  - cmd_valid = 0, cmd_data = 0.
  - csr_rvalid = 0, csr_rdata = 0, csr_err = 0.
- clear:
  - Restores cfg, irq_stat and irq_en to reset values.
  - Does not touch the response slot.
  - A request accepted in the same cycle as clear is answered, but its write is discarded: clear wins.
- Address map (word aligned):
  - STA_BASE+4i: RO.
  - CFG_BASE+4i: RW.
  - CMD_BASE: WO pulse.
  - CMD_BASE+4: IRQ_STAT, read / write-1-to-clear.
  - CMD_BASE+8: IRQ_EN, RW.
- Errors: csr_err=1, no state change, rdata=0. Raised for:
  - csr_addr[1:0]!=0.
  - Unmapped address.
  - Write to STA.
  - Read of CMD.
- Response slot:
  - Single-entry response register. csr_ready = !csr_rvalid || csr_rready, so the slot drains and refills in the same cycle.
  - Every accepted request produces exactly one response beat, 1 cycle after accept.
  - csr_rvalid/rdata/err are held stable while rvalid && !rready.
- Writes take effect on the accept edge, so a read accepted the next cycle returns the new value.
- CFG write: byte lane b updates when wstrb[b]=1.
- CMD write:
  - cmd_valid pulses the cycle after accept, cmd_data = wdata.
  - wstrb is ignored.
  - Back-to-back CMD writes give consecutive pulses.
- IRQ_STAT:
  - Bits at IRQ_NUM and above read 0.
  - Per cycle: stat_next = (stat & ~w1c_mask) | irq_event.
  - A set event wins over a simultaneous W1C of the same bit.
- IRQ_EN: bits at IRQ_NUM and above are not writable and read 0.
- irq is registered, 1 cycle after the stat/en change.
- Read mux: one-hot address decode, registered into the response slot. No combinational path from csr_addr to csr_rdata.

Decomposition:
- Package csr_regbank_pkg holds:
  - Offsets CMD_OFS=0, IRQ_STAT_OFS=4, IRQ_EN_OFS=8.
  - Typedef csr_rsp_t {rdata, err}.
  - Function addr_hit(addr, base, n) returning index and hit.
- One sub-module, csr_rsp_slot: the single-entry response holding register with the valid/ready handshake.

Test Plan:
1. Reset, then read CFG_BASE+4 -> one response beat 1 cycle later with rdata=32'h1, err=0.
2. Write CFG_BASE+0 wdata=32'hAABBCCDD wstrb=4'b0101, then read -> rdata=32'h00BB00DD with CFG_RST=1, i.e. 32'h00BB00DD | 32'h0000_0001 masked per lane = 32'h00BB00DD.
3. Hold csr_rready=0, issue two reads -> first accepted; csr_ready=0 next cycle; rdata stable 3 cycles; raise rready -> second request accepted in the same cycle.
4. Set irq_en=8'h01, pulse irq_event[0] -> irq=1 one cycle later. W1C bit0 in the same cycle as a new event[0] -> stat bit stays 1. W1C alone -> irq=0.
5. Write STA_BASE, read 'h3FC, read CFG_BASE+2 -> three responses, each err=1 and rdata=0, with no register change.
6. Back-to-back CMD writes 5 then 7 -> cmd_valid high 2 cycles with cmd_data 5 then 7. Assert rst mid-burst -> all outputs at reset values next cycle.
